// File: rtl/morse_seq_if.sv
// Control and LED bus of the Morse sequencer.
// The master side drives playback requests and the message.
// The slave side (the sequencer) returns LED levels and status.
interface morse_seq_if #(
    parameter int MSG_LEN = 9
);
    localparam int IDX_W = $clog2(MSG_LEN);

    logic                   i_start;
    logic                   i_stop;
    logic                   i_loop;
    logic [2:0]             i_color;
    logic [2*MSG_LEN-1:0]   i_msg;
    logic                   o_led_r;
    logic                   o_led_g;
    logic                   o_led_b;
    logic                   o_busy;
    logic                   o_done;
    logic [IDX_W-1:0]       o_sym_idx;

    modport master (
        output i_start, i_stop, i_loop, i_color, i_msg,
        input  o_led_r, o_led_g, o_led_b, o_busy, o_done, o_sym_idx
    );

    modport slave (
        input  i_start, i_stop, i_loop, i_color, i_msg,
        output o_led_r, o_led_g, o_led_b, o_busy, o_done, o_sym_idx
    );
endinterface

// File: rtl/morse_seq.sv
// Morse sequencer: plays a latched string of dit/dah/letter-gap symbols
// on an active-low RGB LED. Each symbol is a MARK phase (LED lit with the
// latched colour mask) followed by a SPACE phase (LED dark). Phase lengths
// are whole units of UNIT_CYCLES clocks. The END code is consumed by
// look-ahead so it never costs a cycle. All outputs come straight from flops.
module morse_seq #(
    parameter int UNIT_CYCLES = 1200000,
    parameter int MSG_LEN     = 9
) (
    input  logic        i_clk,
    input  logic        i_rst,
    morse_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(UNIT_CYCLES);
    localparam int IDX_W = $clog2(MSG_LEN);
    localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(MSG_LEN - 1);

    localparam logic [1:0] SYM_DIT = 2'b00;
    localparam logic [1:0] SYM_DAH = 2'b01;
    localparam logic [1:0] SYM_GAP = 2'b10;
    localparam logic [1:0] SYM_END = 2'b11;

    // Word gap is 7 units after the last mark; the last symbol's SPACE gives 1.
    localparam logic [2:0] WGAP_UNITS = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MARK,
        S_SPACE,
        S_WGAP
    } state_t;

    state_t               state_q, state_n;
    logic [CNT_W-1:0]     unit_q, unit_n;     // cycles left in the current unit
    logic [2:0]           units_q, units_n;   // units left in the current phase, incl. current
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic [2:0]           led_q, led_n;       // {b,g,r}, active low
    logic                 busy_q, busy_n;
    logic                 done_q, done_n;

    logic [2*MSG_LEN-1:0] msg_q;
    logic [2:0]           color_q;
    logic                 loop_q;
    logic                 latch;
    logic [2:0]           color_n;
    logic [IDX_W-1:0]     nxt_idx;
    logic [1:0]           nxt_code;

    // Symbol code at index i; out-of-range indices read as END.
    function automatic logic [1:0] sym_at(input logic [2*MSG_LEN-1:0] m,
                                          input logic [IDX_W-1:0] i);
        logic [1:0] s;
        s = SYM_END;
        for (int k = 0; k < MSG_LEN; k++) begin
            if (i == IDX_W'(k)) s = m[2*k +: 2];
        end
        return s;
    endfunction

    // A letter gap has no mark, so it opens directly in SPACE.
    function automatic state_t first_phase(input logic [1:0] code);
        return (code == SYM_GAP) ? S_SPACE : S_MARK;
    endfunction

    function automatic logic [2:0] first_units(input logic [1:0] code);
        logic [2:0] u;
        case (code)
            SYM_DAH: u = 3'd3;
            SYM_GAP: u = 3'd2;
            SYM_DIT: u = 3'd1;
            default: u = 3'd1;
        endcase
        return u;
    endfunction

    // Next-state, counter and output decode.
    always_comb begin
        state_n  = state_q;
        unit_n   = unit_q;
        units_n  = units_q;
        idx_n    = idx_q;
        done_n   = 1'b0;
        latch    = 1'b0;
        nxt_idx  = idx_q + 1'b1;
        nxt_code = sym_at(msg_q, nxt_idx);

        case (state_q)
            S_IDLE: begin
                if (bus.i_start && !bus.i_stop) begin
                    latch = 1'b1;
                    if (bus.i_msg[1:0] == SYM_END) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = first_phase(bus.i_msg[1:0]);
                        units_n = first_units(bus.i_msg[1:0]);
                        unit_n  = UNIT_LAST;
                        idx_n   = '0;
                    end
                end
            end
            default: begin
                if (bus.i_stop) begin
                    state_n = S_IDLE;
                    unit_n  = '0;
                    units_n = '0;
                    idx_n   = '0;
                end else if (unit_q != '0) begin
                    unit_n = unit_q - 1'b1;
                end else if (units_q != 3'd1) begin
                    units_n = units_q - 1'b1;
                    unit_n  = UNIT_LAST;
                end else begin
                    unit_n = UNIT_LAST;
                    case (state_q)
                        S_MARK: begin
                            state_n = S_SPACE;
                            units_n = 3'd1;
                        end
                        S_SPACE: begin
                            if (idx_q == IDX_LAST || nxt_code == SYM_END) begin
                                idx_n = '0;
                                if (loop_q) begin
                                    state_n = S_WGAP;
                                    units_n = WGAP_UNITS;
                                end else begin
                                    state_n = S_IDLE;
                                    unit_n  = '0;
                                    units_n = '0;
                                    done_n  = 1'b1;
                                end
                            end else begin
                                state_n = first_phase(nxt_code);
                                units_n = first_units(nxt_code);
                                idx_n   = nxt_idx;
                            end
                        end
                        S_WGAP: begin
                            state_n = first_phase(sym_at(msg_q, '0));
                            units_n = first_units(sym_at(msg_q, '0));
                            idx_n   = '0;
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        color_n = latch ? bus.i_color : color_q;
        led_n   = (state_n == S_MARK) ? ~color_n : 3'b111;
        busy_n  = (state_n != S_IDLE);
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            unit_q  <= '0;
            units_q <= '0;
            idx_q   <= '0;
            led_q   <= 3'b111;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            unit_q  <= unit_n;
            units_q <= units_n;
            idx_q   <= idx_n;
            led_q   <= led_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // Message, colour and loop mode are captured once, at start.
    always_ff @(posedge i_clk) begin
        if (latch) begin
            msg_q   <= bus.i_msg;
            color_q <= bus.i_color;
            loop_q  <= bus.i_loop;
        end
    end

    assign bus.o_led_r   = led_q[0];
    assign bus.o_led_g   = led_q[1];
    assign bus.o_led_b   = led_q[2];
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.o_sym_idx = idx_q;
endmodule

// File: tb/tb_morse_seq.sv
// Bench for morse_seq with UNIT_CYCLES=4, MSG_LEN=4.
// Stimulus pushes a hand-written per-cycle expected trace into a queue;
// a monitor pops one entry per cycle on the falling edge and compares.
module tb_morse_seq;
    localparam int UNIT_CYCLES = 4;
    localparam int MSG_LEN     = 4;

    logic i_clk;
    logic i_rst;

    morse_seq_if #(.MSG_LEN(MSG_LEN)) bus();

    morse_seq #(.UNIT_CYCLES(UNIT_CYCLES), .MSG_LEN(MSG_LEN)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] led;   // {b,g,r}
        logic       busy;
        logic       done;
        logic [1:0] idx;
    } exp_t;

    typedef struct {
        exp_t e;
        int   test;
        int   cyc;
    } item_t;

    item_t q[$];
    int    checks  = 0;
    int    errors  = 0;
    int    test_id = 0;
    int    cyc_tag = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic begin_test(input int id);
        test_id = id;
        cyc_tag = 0;
    endtask

    task automatic push(input int n, input logic [2:0] led, input logic busy,
                        input logic done, input logic [1:0] idx);
        item_t it;
        for (int i = 0; i < n; i++) begin
            it.e.led  = led;
            it.e.busy = busy;
            it.e.done = done;
            it.e.idx  = idx;
            it.test   = test_id;
            it.cyc    = cyc_tag;
            cyc_tag++;
            q.push_back(it);
        end
    endtask

    task automatic push_idle(input int n);
        push(n, 3'b111, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain t%0d: %0d expected entries left, required 0", test_id, q.size());
            q.delete();
        end
    endtask

    // Monitor: one comparison per cycle while expectations are queued.
    always @(negedge i_clk) begin
        item_t it;
        exp_t  act;
        if (q.size() != 0) begin
            it  = q.pop_front();
            act = {bus.o_led_b, bus.o_led_g, bus.o_led_r, bus.o_busy, bus.o_done, bus.o_sym_idx};
            checks++;
            if (act !== it.e) begin
                errors++;
                $display("FAIL t%0d cyc%0d: got led(bgr)=%b busy=%b done=%b idx=%0d, required led(bgr)=%b busy=%b done=%b idx=%0d",
                         it.test, it.cyc, act.led, act.busy, act.done, act.idx,
                         it.e.led, it.e.busy, it.e.done, it.e.idx);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst       = 1'b1;
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        bus.i_loop  = 1'b0;
        bus.i_color = 3'b000;
        bus.i_msg   = '0;

        // Reset state.
        begin_test(0);
        step();
        step();
        push_idle(2);
        step();
        i_rst = 1'b0;
        drain();

        // Test 1: S = dit dit dit, red.
        begin_test(1);
        bus.i_msg   = 8'b11_00_00_00;
        bus.i_color = 3'b001;
        bus.i_start = 1'b1;
        push_idle(1);
        for (int s = 0; s < 3; s++) begin
            push(4, 3'b110, 1'b1, 1'b0, 2'(s));
            push(4, 3'b111, 1'b1, 1'b0, 2'(s));
        end
        push(1, 3'b111, 1'b0, 1'b1, 2'd0);
        push_idle(1);
        step();
        bus.i_start = 1'b0;
        drain();

        // Test 2: dah, letter gap, dah, dit on green+blue; inputs disturbed while busy.
        begin_test(2);
        bus.i_msg   = 8'b00_01_10_01;
        bus.i_color = 3'b110;
        bus.i_loop  = 1'b0;
        bus.i_start = 1'b1;
        push_idle(1);
        push(12, 3'b001, 1'b1, 1'b0, 2'd0);
        push(4,  3'b111, 1'b1, 1'b0, 2'd0);
        push(8,  3'b111, 1'b1, 1'b0, 2'd1);
        push(12, 3'b001, 1'b1, 1'b0, 2'd2);
        push(4,  3'b111, 1'b1, 1'b0, 2'd2);
        push(4,  3'b001, 1'b1, 1'b0, 2'd3);
        push(4,  3'b111, 1'b1, 1'b0, 2'd3);
        push(1,  3'b111, 1'b0, 1'b1, 2'd0);
        push_idle(1);
        step();
        bus.i_start = 1'b0;
        repeat (19) step();
        bus.i_msg   = 8'b00_00_00_00;
        bus.i_color = 3'b111;
        bus.i_loop  = 1'b1;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        drain();

        // Test 3: looping single dit on green, stopped after 200 cycles.
        begin_test(3);
        bus.i_msg   = 8'b11_11_11_00;
        bus.i_color = 3'b010;
        bus.i_loop  = 1'b1;
        bus.i_start = 1'b1;
        push_idle(1);
        for (int c = 1; c <= 200; c++) begin
            if (((c - 1) % 32) < 4) push(1, 3'b101, 1'b1, 1'b0, 2'd0);
            else                    push(1, 3'b111, 1'b1, 1'b0, 2'd0);
        end
        push_idle(2);
        step();
        bus.i_start = 1'b0;
        bus.i_loop  = 1'b0;
        repeat (199) step();
        bus.i_stop = 1'b1;
        step();
        bus.i_stop = 1'b0;
        drain();

        // Test 4: stop in the middle of a dah, then replay from symbol 0.
        begin_test(4);
        bus.i_msg   = 8'b11_00_00_01;
        bus.i_color = 3'b001;
        bus.i_start = 1'b1;
        push_idle(1);
        push(6,  3'b110, 1'b1, 1'b0, 2'd0);
        push_idle(4);
        push(12, 3'b110, 1'b1, 1'b0, 2'd0);
        push(4,  3'b111, 1'b1, 1'b0, 2'd0);
        push(4,  3'b110, 1'b1, 1'b0, 2'd1);
        push(4,  3'b111, 1'b1, 1'b0, 2'd1);
        push(4,  3'b110, 1'b1, 1'b0, 2'd2);
        push(4,  3'b111, 1'b1, 1'b0, 2'd2);
        push(1,  3'b111, 1'b0, 1'b1, 2'd0);
        push_idle(1);
        step();
        bus.i_start = 1'b0;
        repeat (5) step();
        bus.i_stop = 1'b1;
        step();
        bus.i_stop = 1'b0;
        repeat (3) step();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        drain();

        // Test 5: asynchronous reset in the middle of a mark.
        begin_test(5);
        bus.i_msg   = 8'b11_00_00_00;
        bus.i_color = 3'b100;
        bus.i_start = 1'b1;
        push_idle(1);
        push(2, 3'b011, 1'b1, 1'b0, 2'd0);
        push_idle(4);
        step();
        bus.i_start = 1'b0;
        step();
        step();
        #1;
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        drain();

        // Test 6a: END as the first symbol completes at once.
        begin_test(6);
        bus.i_msg   = 8'b00_00_00_11;
        bus.i_color = 3'b111;
        bus.i_start = 1'b1;
        push_idle(1);
        push(1, 3'b111, 1'b0, 1'b1, 2'd0);
        push_idle(1);
        step();
        bus.i_start = 1'b0;
        drain();

        // Test 6b: start and stop together while idle -> nothing starts.
        begin_test(7);
        bus.i_msg   = 8'b11_00_00_00;
        bus.i_color = 3'b111;
        bus.i_start = 1'b1;
        bus.i_stop  = 1'b1;
        push_idle(4);
        step();
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
